// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Package   : i2c_pkg
// Purpose   : Shared I2C definitions used by the master and target blocks.
//             Holds the protocol state encoding, the ACK/NACK bus levels, the
//             R/W bit encoding and a 3-input majority helper used by the
//             optional line glitch filter.
// Revision  : 1.0  initial release
// ============================================================================
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8
  } i2c_state_e;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module    : i2c_line_sync
// Purpose   : Brings SCL/SDA into the clk domain (2-flop synchroniser),
//             optionally cleans them with a 3-sample majority filter, and
//             produces 1-cycle scl_rise/scl_fall/start/stop pulses.
// Macro     : I2C_TGT_GLITCH_FILTER_EN - enables the majority filter
//             (+2 clk latency, rejects pulses of 1 clk or less).
// Ports     : clk, reset   - system clock, synchronous active-high reset
//             scl_in       - raw SCL
//             sda_in       - raw (resolved) SDA
//             sda_s        - cleaned SDA level
//             scl_rise/scl_fall/start/stop - 1-cycle event pulses
// Revision  : 1.0  initial release
// ============================================================================
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       w_scl_clean;
  logic       w_sda_clean;
  logic       r_scl_prev;
  logic       r_sda_prev;

  // Idle bus is high on both lines, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist;
  logic [1:0] r_sda_hist;
  logic       r_scl_filt;
  logic       r_sda_filt;

  // Majority over the current synced sample and the two previous ones:
  // a single-cycle excursion can only ever hold one of the three votes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      r_scl_filt <= maj3({r_scl_hist, r_scl_sync[1]});
      r_sda_filt <= maj3({r_sda_hist, r_sda_sync[1]});
    end
  end

  assign w_scl_clean = r_scl_filt;
  assign w_sda_clean = r_sda_filt;
`else
  assign w_scl_clean = r_scl_sync[1];
  assign w_sda_clean = r_sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl_clean;
      r_sda_prev <= w_sda_clean;
    end
  end

  assign sda_s    = w_sda_clean;
  assign scl_rise = w_scl_clean & ~r_scl_prev;
  assign scl_fall = ~w_scl_clean & r_scl_prev;
  // SDA may only move while SCL is low during data; a move with SCL held
  // high across both samples is a bus condition.
  assign start    = w_scl_clean & r_scl_prev & r_sda_prev & ~w_sda_clean;
  assign stop     = w_scl_clean & r_scl_prev & ~r_sda_prev & w_sda_clean;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module    : i2c_target_regs
// Purpose   : I2C target with a 2**REG_AW byte register file. Matches a
//             7-bit device address, takes a register pointer byte, then
//             serves auto-incrementing reads/writes. SDA is open drain.
// Macro     : I2C_TGT_GLITCH_FILTER_EN - majority filter on SCL/SDA.
// Ports     : clk, reset            - system clock, sync active-high reset
//             scl, sda              - I2C bus (sda drives 0 or z only)
//             host_we/addr/wdata    - host-side register write port
//             wr_strobe/addr/data   - report of each committed bus write
//             busy                  - addressed and transfer in progress
// Revision  : 1.0  initial release
// ============================================================================
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter int         REG_AW   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  inout  wire               sda,
  input  logic              host_we,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int c_num_regs = 1 << REG_AW;

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl),
    .sda_in   (sda),
    .sda_s    (w_sda),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start    (w_start),
    .stop     (w_stop)
  );

  i2c_state_e        r_state, w_state_nxt;
  logic [2:0]        r_bitcnt, w_cnt_nxt;
  logic [6:0]        r_shift;
  logic [7:0]        r_tx;
  logic [REG_AW-1:0] r_ptr;
  logic [7:0]        r_regs [c_num_regs];
  logic              r_sda_low, w_sda_low_nxt;
  logic              r_phase, w_phase_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_rw, w_rw_nxt;
  logic              r_wr_strobe;
  logic [REG_AW-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              w_shift_en, w_commit, w_ptr_load, w_ptr_inc;
  logic              w_load_tx, w_tx_shift;
  logic [7:0]        w_byte;
  logic              w_addr_match;

  assign w_byte       = {r_shift, w_sda};
  assign w_addr_match = (w_byte[7:1] == DEV_ADDR);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---- next state ----
  // ACK states run two SCL falls: the first starts the ACK drive, the
  // second (r_phase set) ends the ACK slot and leaves the state.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else begin
      case (r_state)
        ST_ADDR:
          if (w_scl_rise && r_bitcnt == 3'd0)
            w_state_nxt = w_addr_match ? ST_ADDR_ACK : ST_IDLE;
        ST_ADDR_ACK:
          if (w_scl_fall && r_phase)
            w_state_nxt = (r_rw == I2C_RW_READ) ? ST_RDATA : ST_PTR;
        ST_PTR:
          if (w_scl_rise && r_bitcnt == 3'd0) w_state_nxt = ST_PTR_ACK;
        ST_PTR_ACK:
          if (w_scl_fall && r_phase) w_state_nxt = ST_WDATA;
        ST_WDATA:
          if (w_scl_rise && r_bitcnt == 3'd0) w_state_nxt = ST_WDATA_ACK;
        ST_WDATA_ACK:
          if (w_scl_fall && r_phase) w_state_nxt = ST_WDATA;
        ST_RDATA:
          if (w_scl_fall && r_bitcnt == 3'd0) w_state_nxt = ST_RDATA_ACK;
        ST_RDATA_ACK:
          if (w_scl_rise && w_sda == I2C_NACK)  w_state_nxt = ST_IDLE;
          else if (w_scl_fall && r_phase)       w_state_nxt = ST_RDATA;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---- outputs / datapath controls ----
  always_comb begin
    w_shift_en    = 1'b0;
    w_commit      = 1'b0;
    w_ptr_load    = 1'b0;
    w_ptr_inc     = 1'b0;
    w_load_tx     = 1'b0;
    w_tx_shift    = 1'b0;
    w_cnt_nxt     = r_bitcnt;
    w_sda_low_nxt = r_sda_low;
    w_phase_nxt   = r_phase;
    w_busy_nxt    = r_busy;
    w_rw_nxt      = r_rw;
    if (w_stop) begin
      w_sda_low_nxt = 1'b0;
      w_phase_nxt   = 1'b0;
      w_busy_nxt    = 1'b0;
    end else if (w_start) begin
      w_cnt_nxt     = 3'd7;
      w_sda_low_nxt = 1'b0;
      w_phase_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA:
          if (w_scl_rise) begin
            w_shift_en = 1'b1;
            w_cnt_nxt  = r_bitcnt - 3'd1;
            if (r_bitcnt == 3'd0) begin
              if (r_state == ST_ADDR) begin
                w_busy_nxt = w_addr_match;
                w_rw_nxt   = w_sda;
              end else if (r_state == ST_PTR) begin
                w_ptr_load = 1'b1;
              end else begin
                w_commit  = 1'b1;
                w_ptr_inc = 1'b1;
              end
            end
          end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK:
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_low_nxt = 1'b1;
              w_phase_nxt   = 1'b1;
            end else begin
              w_phase_nxt = 1'b0;
              w_cnt_nxt   = 3'd7;
              if (r_state == ST_ADDR_ACK && r_rw == I2C_RW_READ) begin
                w_load_tx     = 1'b1;
                w_sda_low_nxt = ~r_regs[r_ptr][7];
              end else begin
                w_sda_low_nxt = 1'b0;
              end
            end
          end
        ST_RDATA:
          if (w_scl_fall) begin
            if (r_bitcnt != 3'd0) begin
              w_tx_shift    = 1'b1;
              w_cnt_nxt     = r_bitcnt - 3'd1;
              w_sda_low_nxt = ~r_tx[6];
            end else begin
              w_sda_low_nxt = 1'b0;
              w_ptr_inc     = 1'b1;
            end
          end
        ST_RDATA_ACK:
          if (w_scl_rise) begin
            if (w_sda == I2C_NACK) w_busy_nxt  = 1'b0;
            else                   w_phase_nxt = 1'b1;
          end else if (w_scl_fall && r_phase) begin
            w_phase_nxt   = 1'b0;
            w_load_tx     = 1'b1;
            w_cnt_nxt     = 3'd7;
            w_sda_low_nxt = ~r_regs[r_ptr][7];
          end
        default: ;
      endcase
    end
  end

  // ---- datapath registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitcnt    <= 3'd7;
      r_shift     <= '0;
      r_tx        <= '0;
      r_ptr       <= '0;
      r_sda_low   <= 1'b0;
      r_phase     <= 1'b0;
      r_busy      <= 1'b0;
      r_rw        <= I2C_RW_WRITE;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < c_num_regs; i++) r_regs[i] <= '0;
    end else begin
      r_bitcnt    <= w_cnt_nxt;
      r_sda_low   <= w_sda_low_nxt;
      r_phase     <= w_phase_nxt;
      r_busy      <= w_busy_nxt;
      r_rw        <= w_rw_nxt;
      r_wr_strobe <= w_commit;
      if (w_shift_en) r_shift <= w_byte[6:0];
      // Snapshot isolates the outgoing byte from host writes mid-byte.
      if (w_load_tx)       r_tx <= r_regs[r_ptr];
      else if (w_tx_shift) r_tx <= {r_tx[6:0], 1'b0};
      if (w_ptr_load)     r_ptr <= w_byte[REG_AW-1:0];
      else if (w_ptr_inc) r_ptr <= r_ptr + REG_AW'(1);
      if (w_commit) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_byte;
      end
      // Host port has priority over a bus write to the same index.
      for (int i = 0; i < c_num_regs; i++) begin
        if (host_we && host_addr == REG_AW'(i))   r_regs[i] <= host_wdata;
        else if (w_commit && r_ptr == REG_AW'(i)) r_regs[i] <= w_byte;
      end
    end
  end

  assign sda       = r_sda_low ? 1'b0 : 1'bz;
  assign busy      = r_busy;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : tb_i2c_target_regs
// Purpose   : Directed bench for i2c_target_regs. A bit-banged I2C master
//             (SCL = 32 clk periods) exercises writes, reads, pointer wrap,
//             address mismatch, reset mid-ACK and SDA glitch handling.
// Macro     : I2C_TGT_GLITCH_FILTER_EN selects the glitch expectation.
// Revision  : 1.0  initial release
// ============================================================================
module tb_i2c_target_regs;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic       host_we = 1'b0;
  logic [1:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  wire        sda;
  wire        wr_strobe;
  wire  [1:0] wr_addr;
  wire  [7:0] wr_data;
  wire        busy;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target_regs #(.DEV_ADDR(7'h48), .REG_AW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl),
    .sda        (sda),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  int         n_checks = 0;
  int         n_pass = 0;
  int         strobe_cnt = 0;
  int         target_low_cnt = 0;
  int         start_cnt = 0;
  logic [1:0] strobe_addr [2];
  logic [7:0] strobe_data [2];

  always @(posedge clk) begin
    if (wr_strobe) begin
      if (strobe_cnt < 2) begin
        strobe_addr[strobe_cnt] = wr_addr;
        strobe_data[strobe_cnt] = wr_data;
      end
      strobe_cnt = strobe_cnt + 1;
    end
    if (!m_sda_low && sda === 1'b0) target_low_cnt = target_low_cnt + 1;
    if (dut.w_start) start_cnt = start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic q();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; scl = 1'b1; q();
    m_sda_low = 1'b1; q();
    scl = 1'b0; q();
  endtask

  task automatic i2c_rstart();
    m_sda_low = 1'b0; q();
    scl = 1'b1; q();
    m_sda_low = 1'b1; q();
    scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; q();
    scl = 1'b1; q();
    m_sda_low = 1'b0; q();
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; q();
    scl = 1'b1; q(); q();
    scl = 1'b0; q();
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; q();
    scl = 1'b1; q();
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    q();
    scl = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  logic       ack;
  logic [7:0] rd;
  logic [7:0] exp_rd [4];
  logic [7:0] addr_byte;

  initial begin
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_sda", sda, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_wr_strobe", wr_strobe, 1'b0);
    chk("reset_wr_addr", wr_addr, 2'd0);
    chk("reset_wr_data", wr_data, 8'h00);

    // Test 1: bus write of two bytes at pointer 1
    strobe_cnt = 0;
    i2c_start();
    write_byte(8'h90, ack); chk("t1_addr_ack", ack, 1'b0);
    chk("t1_busy_hi", busy, 1'b1);
    write_byte(8'h01, ack); chk("t1_ptr_ack", ack, 1'b0);
    write_byte(8'hA5, ack); chk("t1_d0_ack", ack, 1'b0);
    write_byte(8'h3C, ack); chk("t1_d1_ack", ack, 1'b0);
    i2c_stop(); q();
    chk("t1_busy_lo", busy, 1'b0);
    chk("t1_strobe_cnt", strobe_cnt, 2);
    chk("t1_wr_addr0", strobe_addr[0], 2'd1);
    chk("t1_wr_data0", strobe_data[0], 8'hA5);
    chk("t1_wr_addr1", strobe_addr[1], 2'd2);
    chk("t1_wr_data1", strobe_data[1], 8'h3C);
    // read back regs[1..2]
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h01, ack);
    i2c_rstart();
    write_byte(8'h91, ack); chk("t1_rd_addr_ack", ack, 1'b0);
    read_byte(1'b0, rd); chk("t1_rd_reg1", rd, 8'hA5);
    read_byte(1'b1, rd); chk("t1_rd_reg2", rd, 8'h3C);
    i2c_stop(); q();

    // Test 2: host preload then 4-byte read from pointer 0
    host_wr(2'd0, 8'h11); host_wr(2'd1, 8'h22);
    host_wr(2'd2, 8'h33); host_wr(2'd3, 8'h44);
    exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h44;
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h00, ack);
    i2c_rstart();
    write_byte(8'h91, ack);
    for (int i = 0; i < 4; i++) begin
      read_byte((i == 3), rd);
      chk($sformatf("t2_rd%0d", i), rd, exp_rd[i]);
    end
    q();
    chk("t2_busy_after_nack", busy, 1'b0);
    i2c_stop(); q();

    // Test 3: wrong address
    target_low_cnt = 0;
    i2c_start();
    write_byte(8'h92, ack); chk("t3_nack", ack, 1'b1);
    chk("t3_busy", busy, 1'b0);
    i2c_stop(); q();
    chk("t3_never_driven", target_low_cnt, 0);

    // Test 4: pointer wrap 3 -> 0
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h03, ack);
    i2c_rstart();
    write_byte(8'h91, ack);
    read_byte(1'b0, rd); chk("t4_rd_reg3", rd, 8'h44);
    read_byte(1'b1, rd); chk("t4_rd_reg0_wrap", rd, 8'h11);
    i2c_stop(); q();

    // Test 5: reset while target holds the address ACK low
    i2c_start();
    addr_byte = 8'h90;
    for (int i = 7; i >= 0; i--) write_bit(addr_byte[i]);
    m_sda_low = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_ack_driven", sda, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_released", sda, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_busy_reset", busy, 1'b0);
    i2c_rstart();
    write_byte(8'h91, ack); chk("t5_addr_ack", ack, 1'b0);
    read_byte(1'b1, rd); chk("t5_rd_reg0", rd, 8'h00);
    i2c_stop(); q();

    // Test 6: one-clk SDA low pulse with SCL high
    q();
    start_cnt = 0;
    @(negedge clk); m_sda_low = 1'b1;
    @(negedge clk); m_sda_low = 1'b0;
    repeat (12) @(negedge clk);
`ifdef I2C_TGT_GLITCH_FILTER_EN
    chk("t6_glitch_start", start_cnt, 0);
`else
    chk("t6_glitch_start", start_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
